// File: rtl/lc3b_types.sv
// Shared LC-3b memory types, plus the state and grant encodings used by the
// instruction/data cache arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8word;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam lc3b_word  WORD_ZERO  = 16'h0000;
  localparam lc3b_8word LINE_ZERO  = 128'h0;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between the I-cache and the D-cache,
// one line transaction at a time, round-robin on simultaneous requests.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset_n,

  input  logic      i_pmem_read,
  input  lc3b_word  i_pmem_address,
  output lc3b_8word i_pmem_rdata,
  output logic      i_pmem_resp,

  input  logic      d_pmem_read,
  input  logic      d_pmem_write,
  input  lc3b_word  d_pmem_address,
  input  lc3b_8word d_pmem_wdata,
  output lc3b_8word d_pmem_rdata,
  output logic      d_pmem_resp,

  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output lc3b_8word pmem_wdata,
  input  lc3b_8word pmem_rdata,
  input  logic      pmem_resp
);

  arb_state_t state;
  grant_t     last_grant;
  lc3b_word   addr_q;
  lc3b_8word  wdata_q;
  logic       read_q;
  logic       write_q;

  logic i_pending;
  logic d_pending;
  logic grant_i;

  assign i_pending = i_pmem_read;
  assign d_pending = d_pmem_read | d_pmem_write;
  // On a tie the side that did not win last time gets the port.
  assign grant_i   = i_pending & (~d_pending | (last_grant == GRANT_D));

  // Arbitration state, captured request and registered memory strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_I;
      addr_q     <= WORD_ZERO;
      wdata_q    <= LINE_ZERO;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_i) begin
            state      <= ARB_SERVE_I;
            last_grant <= GRANT_I;
            addr_q     <= i_pmem_address;
            read_q     <= 1'b1;
            write_q    <= 1'b0;
          end else if (d_pending) begin
            state      <= ARB_SERVE_D;
            last_grant <= GRANT_D;
            addr_q     <= d_pmem_address;
            wdata_q    <= d_pmem_wdata;
            // A read+write collision is treated as a writeback.
            read_q     <= ~d_pmem_write;
            write_q    <= d_pmem_write;
          end else begin
            state   <= ARB_IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) begin
            state   <= ARB_IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end else begin
            state <= state;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state == ARB_SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == ARB_SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_cache_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: one outstanding transaction (owner, op, address, data)
  // and who won the port most recently.
  bit           m_busy;
  bit           m_owner_d;
  bit           m_last_d;
  bit           m_write;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;

  int i_seen = 0;
  int d_seen = 0;
  bit order_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_last_d = 1'b0;
    m_write  = 1'b0;
    m_addr   = 16'h0000;
    m_wdata  = 128'h0;
  endtask

  task automatic model_update();
    bit ip, dp;
    ip = i_pmem_read;
    dp = d_pmem_read | d_pmem_write;
    if (!m_busy) begin
      if (ip && (!dp || m_last_d)) begin
        m_busy = 1'b1; m_owner_d = 1'b0; m_last_d = 1'b0;
        m_addr = i_pmem_address; m_write = 1'b0;
      end else if (dp) begin
        m_busy = 1'b1; m_owner_d = 1'b1; m_last_d = 1'b1;
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_write = d_pmem_write;
      end
    end else if (pmem_resp) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("pmem_read",    {127'h0, pmem_read},   {127'h0, m_busy & ~m_write});
    chk("pmem_write",   {127'h0, pmem_write},  {127'h0, m_busy & m_write});
    chk("pmem_address", {112'h0, pmem_address}, {112'h0, m_addr});
    chk("pmem_wdata",   pmem_wdata, m_wdata);
    chk("i_pmem_resp",  {127'h0, i_pmem_resp}, {127'h0, m_busy & ~m_owner_d & pmem_resp});
    chk("d_pmem_resp",  {127'h0, d_pmem_resp}, {127'h0, m_busy & m_owner_d & pmem_resp});
    chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    if (i_pmem_resp === 1'b1) begin i_seen++; order_q.push_back(1'b0); end
    if (d_pmem_resp === 1'b1) begin d_seen++; order_q.push_back(1'b1); end
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic wait_resp(input int n);
    pmem_resp = 1'b0;
    for (int k = 1; k < n; k++) step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int i0, d0;
    reset_n = 1'b0;
    i_pmem_read = 1'b0; i_pmem_address = 16'h0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = 16'h0; d_pmem_wdata = 128'h0;
    pmem_rdata = 128'h0; pmem_resp = 1'b0;
    m_owner_d = 1'b0;
    #2;
    do_reset();

    // Single I-cache read, memory answers on the third strobe cycle.
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    step();
    chk("i_read_strobe", {127'h0, pmem_read}, 128'h1);
    pmem_rdata = 128'h0123456789ABCDEF_FEDCBA98765432A5;
    wait_resp(3);
    i_pmem_read = 1'b0;
    step();
    chk("i_resp_count", i_seen, 1);
    chk("d_resp_none",  d_seen, 0);

    // Simultaneous requests after reset: D, then I, then D again on the next tie.
    do_reset();
    order_q.delete();
    i_pmem_read = 1'b1; i_pmem_address = 16'h2000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
    step();
    chk("tie_first_addr", {112'h0, pmem_address}, {112'h0, 16'h3000});
    wait_resp(2);
    d_pmem_read = 1'b0;
    step();
    wait_resp(2);
    i_pmem_read = 1'b0;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    step();
    wait_resp(1);
    d_pmem_read = 1'b0;
    step();
    wait_resp(1);
    i_pmem_read = 1'b0;
    step();
    chk("order_len", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("order_0", {127'h0, order_q[0]}, 128'h1);
      chk("order_1", {127'h0, order_q[1]}, 128'h0);
      chk("order_2", {127'h0, order_q[2]}, 128'h1);
      chk("order_3", {127'h0, order_q[3]}, 128'h0);
    end

    // D writeback; address changes mid-serve must not reach memory.
    d_pmem_write = 1'b1; d_pmem_address = 16'h4000;
    d_pmem_wdata = 128'h00112233445566778899AABBCCDDEEFF;
    step();
    d_pmem_address = 16'hBEEF; d_pmem_wdata = 128'h5;
    step();
    chk("wb_addr_stable", {112'h0, pmem_address}, {112'h0, 16'h4000});
    chk("wb_wdata", pmem_wdata, 128'h00112233445566778899AABBCCDDEEFF);
    chk("wb_strobe", {126'h0, pmem_write, pmem_read}, 128'h2);
    wait_resp(2);
    d_pmem_write = 1'b0;
    step();

    // Illegal read+write from D is captured as a write.
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h5550;
    step();
    chk("rw_collide", {126'h0, pmem_write, pmem_read}, 128'h2);
    wait_resp(1);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    step();

    // Reset during SERVE_D aborts with no response; the next tie goes to D.
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 16'h6000;
    step();
    step();
    d0 = d_seen;
    pmem_resp = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_strobes", {126'h0, pmem_write, pmem_read}, 128'h0);
    chk("abort_no_resp", {127'h0, d_pmem_resp}, 128'h0);
    model_reset();
    step();
    pmem_resp = 1'b0;
    reset_n = 1'b1;
    chk("abort_resp_count", d_seen, d0);
    i_pmem_read = 1'b1; i_pmem_address = 16'h7000; d_pmem_address = 16'h6100;
    step();
    chk("post_reset_tie", {112'h0, pmem_address}, {112'h0, 16'h6100});
    wait_resp(2);
    d_pmem_read = 1'b0;
    step();
    wait_resp(1);
    i_pmem_read = 1'b0;
    step();

    // Spurious memory response while idle.
    i0 = i_seen; d0 = d_seen;
    pmem_resp = 1'b1;
    step(); step(); step();
    pmem_resp = 1'b0;
    chk("spurious_i", i_seen, i0);
    chk("spurious_d", d_seen, d0);

    // Randomized traffic: requests may toggle, collide or drop mid-serve.
    for (int c = 0; c < 600; c++) begin
      i_pmem_read    = ($urandom_range(0, 3) != 0) ? i_pmem_read : ~i_pmem_read;
      d_pmem_read    = ($urandom_range(0, 3) != 0) ? d_pmem_read : ~d_pmem_read;
      d_pmem_write   = ($urandom_range(0, 4) != 0) ? d_pmem_write : ~d_pmem_write;
      i_pmem_address = 16'($urandom);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp      = ($urandom_range(0, 2) == 0);
      reset_n        = ($urandom_range(0, 199) != 0);
      if (!reset_n) begin
        #1;
        model_reset();
        chk("rand_async_reset", {126'h0, pmem_write, pmem_read}, 128'h0);
      end
      step();
      reset_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
